divmod: RTL and testbench
=========================

Name: divmod

Overview:
- Iterative signed integer divider that returns both quotient and remainder.
- Sits on the stb/ack stream fabric as a responder. Takes dividend (in1) and divisor (in2) from an initiator such as a *_test stimulus process, and returns the quotient on out1 and the remainder on out2.
- Gives the test suite one block that checks `/` and `%` semantics together on the same operand pair.

Parameters:
- bits, 16, data width of all streams and operands (two's complement, signed); must be >= 2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active high
- in1  input  bits  dividend
- in1_stb  input  1  dividend valid
- in1_ack  output  1  dividend accepted
- in2  input  bits  divisor
- in2_stb  input  1  divisor valid
- in2_ack  output  1  divisor accepted
- out1  output  bits  quotient
- out1_stb  output  1  quotient valid
- out1_ack  input  1  quotient accepted
- out2  output  bits  remainder
- out2_stb  output  1  remainder valid
- out2_ack  input  1  remainder accepted

Behaviour:
- Handshake:
  - A word transfers on a rising clk edge where stb and ack are both high.
  - Producer holds data and stb stable until the transfer edge.
  - All block outputs are registered.
- Reset (asynchronous, rst=1):
  - state=GET_A.
  - in1_ack=1, in2_ack=0.
  - out1_stb=0, out2_stb=0, out1=0, out2=0.
  - Reset mid-operation abandons the calculation; no partial result is ever emitted.
- GET_A:
  - in1_ack=1.
  - On in1 transfer: latch dividend, in1_ack<=0, in2_ack<=1, go to GET_B.
- GET_B:
  - On in2 transfer: latch divisor, in2_ack<=0, go to PREP.
  - in2_stb asserted during GET_A is ignored (no ack) until GET_B. Operands are strictly ordered in1 then in2.
- PREP (1 cycle):
  - Take magnitudes |a|, |b| as bits-wide unsigned; |-2^(bits-1)| = 2^(bits-1) is representable unsigned.
  - Record sign_q = sign(a) XOR sign(b) and sign_r = sign(a).
  - Clear partial remainder; load counter = bits-1.
- DIVIDE (exactly bits cycles), restoring shift-subtract, one quotient bit per cycle, MSB first:
  - r = {r, next dividend bit}.
  - If r >= |b|: r -= |b| and the quotient bit is 1.
  - Partial remainder is bits+1 wide.
  - When the counter reaches 0, go to FIX.
- FIX (1 cycle):
  - out1 = sign_q ? -q : q.
  - out2 = sign_r ? -r : r.
  - Truncating division: quotient rounds toward zero; remainder takes the dividend's sign.
  - Set out1_stb=1 and out2_stb=1; go to PUT.
- Divide by zero (divisor 0):
  - The DIVIDE loop runs normally; the result is forced in FIX.
  - out1 = all ones (-1); out2 = dividend unchanged.
  - Latency is unchanged.
- Overflow: -2^(bits-1) / -1 gives quotient -2^(bits-1) (wraps) and remainder 0. No error flag.
- PUT:
  - out1_stb drops on its own transfer edge; out2_stb drops on its own transfer edge. The two outputs are independent and may complete in either order or the same cycle.
  - When both have transferred: in1_ack<=1 and return to GET_A.
  - No new operands are accepted until both results are consumed.
- Latency: in2 transfer edge to out1_stb/out2_stb high is exactly bits+2 cycles (PREP + bits DIVIDE + FIX). With both acks held high, the earliest next in1 transfer is 1 cycle after the result transfer.
- Throughput: at most one operation per bits+5 cycles.

Test Plan:
- 100 / 7, acks high → out1=14 (0x000E), out2=2; out stb rises exactly 18 cycles after the in2 transfer.
- -100 / 7 → out1=0xFFF2 (-14), out2=0xFFFE (-2). Then 100 / -7 → 0xFFF2, 2. Then -100 / -7 → 14, 0xFFFE.
- Boundaries:
  - 7 / 0 → out1=0xFFFF, out2=7.
  - 0x8000 / 0xFFFF → out1=0x8000, out2=0.
  - 0x8000 / 1 → 0x8000, 0.
  - 5 / 9 → 0, 5.
- Backpressure:
  - Hold out2_ack low 5 cycles while out1_ack is high. out1 transfers immediately; out2_stb stays high with a stable value; in1_ack stays 0 until the out2 transfer, then rises.
- Ordering: assert in2_stb before in1_stb → in2_ack stays 0 until in1 has transferred; the result uses the correct operand roles.
- Reset mid-DIVIDE: pulse rst asynchronously (not clock-aligned) 4 cycles after the in2 transfer.
  - Outputs return to reset values immediately; no stb is seen.
  - A following 50 / 5 yields 10, 0.
- Random sweep: 1000 random signed pairs vs a reference model (C truncation semantics plus the divide-by-zero rule), with random ack stalls.

Source files
------------

// File: rtl/divmod.sv
// divmod: iterative signed divider returning the truncated quotient on out1 and the remainder on out2.
// Latency: bits+2 cycles from the in2 transfer edge to out1_stb/out2_stb (PREP + bits DIVIDE + FIX).
// Backpressure: each result is held until its own ack; no new operands are accepted until both are consumed.
module divmod #(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] in1,
  input  logic            in1_stb,
  output logic            in1_ack,
  input  logic [bits-1:0] in2,
  input  logic            in2_stb,
  output logic            in2_ack,
  output logic [bits-1:0] out1,
  output logic            out1_stb,
  input  logic            out1_ack,
  output logic [bits-1:0] out2,
  output logic            out2_stb,
  input  logic            out2_ack
);

  localparam int CW = (bits > 2) ? $clog2(bits) : 1;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    PREP   = 3'd2,
    DIVIDE = 3'd3,
    FIX    = 3'd4,
    PUT    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic            in1_ack_nxt, in2_ack_nxt, out1_stb_nxt, out2_stb_nxt;
  logic            in1_fire, in2_fire, out1_fire, out2_fire;

  logic [bits-1:0] a_reg;      // dividend as received
  logic [bits-1:0] b_reg;      // divisor as received
  logic [bits-1:0] b_mag;      // |divisor|, unsigned
  logic [bits-1:0] dq;         // shifts out dividend bits, shifts in quotient bits
  logic [bits-1:0] rem;        // partial remainder, always < b_mag between steps
  logic            sign_q, sign_r;
  logic [CW-1:0]   cnt;

  logic [bits:0]   rem_sh, rem_sub;
  logic            q_bit;
  logic            b_zero;
  logic [bits-1:0] q_fix, r_fix;
  logic            unused_rem_msb;

  assign in1_fire  = in1_stb  & in1_ack;
  assign in2_fire  = in2_stb  & in2_ack;
  assign out1_fire = out1_stb & out1_ack;
  assign out2_fire = out2_stb & out2_ack;

  // One restoring step: bring down the next dividend bit and try to subtract |b|.
  always_comb begin
    rem_sh  = {rem, dq[bits-1]};
    rem_sub = rem_sh - {1'b0, b_mag};
    q_bit   = (rem_sh >= {1'b0, b_mag});
  end

  // After a successful subtract the difference is below |b|, so its top bit is always zero.
  assign unused_rem_msb = rem_sub[bits];

  // Sign fix-up of the unsigned result; a zero divisor forces quotient -1 and passes the dividend through.
  always_comb begin
    b_zero = (b_reg == '0);
    q_fix  = sign_q ? -dq : dq;
    r_fix  = sign_r ? -rem : rem;
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_reg;
    end
  end

  // Next-state and handshake-flag logic; every flag holds its value unless a transition changes it.
  always_comb begin
    state_nxt    = state;
    in1_ack_nxt  = in1_ack;
    in2_ack_nxt  = in2_ack;
    out1_stb_nxt = out1_stb;
    out2_stb_nxt = out2_stb;
    case (state)
      GET_A: begin
        if (in1_fire) begin
          in1_ack_nxt = 1'b0;
          in2_ack_nxt = 1'b1;
          state_nxt   = GET_B;
        end
      end
      GET_B: begin
        if (in2_fire) begin
          in2_ack_nxt = 1'b0;
          state_nxt   = PREP;
        end
      end
      PREP: state_nxt = DIVIDE;
      DIVIDE: begin
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        out1_stb_nxt = 1'b1;
        out2_stb_nxt = 1'b1;
        state_nxt    = PUT;
      end
      PUT: begin
        if (out1_fire) out1_stb_nxt = 1'b0;
        if (out2_fire) out2_stb_nxt = 1'b0;
        if (!out1_stb_nxt && !out2_stb_nxt) begin
          in1_ack_nxt = 1'b1;
          state_nxt   = GET_A;
        end
      end
      default: begin
        state_nxt    = GET_A;
        in1_ack_nxt  = 1'b1;
        in2_ack_nxt  = 1'b0;
        out1_stb_nxt = 1'b0;
        out2_stb_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GET_A;
      in1_ack  <= 1'b1;
      in2_ack  <= 1'b0;
      out1_stb <= 1'b0;
      out2_stb <= 1'b0;
    end else begin
      state    <= state_nxt;
      in1_ack  <= in1_ack_nxt;
      in2_ack  <= in2_ack_nxt;
      out1_stb <= out1_stb_nxt;
      out2_stb <= out2_stb_nxt;
    end
  end

  // Datapath: operand capture, magnitude prep, shift-subtract loop and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      b_mag  <= '0;
      dq     <= '0;
      rem    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      cnt    <= '0;
      out1   <= '0;
      out2   <= '0;
    end else begin
      case (state)
        GET_A: if (in1_fire) a_reg <= in1;
        GET_B: if (in2_fire) b_reg <= in2;
        PREP: begin
          dq     <= a_reg[bits-1] ? -a_reg : a_reg;
          b_mag  <= b_reg[bits-1] ? -b_reg : b_reg;
          sign_q <= a_reg[bits-1] ^ b_reg[bits-1];
          sign_r <= a_reg[bits-1];
          rem    <= '0;
          cnt    <= CW'(bits - 1);
        end
        DIVIDE: begin
          rem <= q_bit ? rem_sub[bits-1:0] : rem_sh[bits-1:0];
          dq  <= {dq[bits-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          out1 <= q_fix;
          out2 <= r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divmod.sv
// tb_divmod: randomized and directed checks of divmod against a plain-arithmetic reference model.
// Latency: results expected bits+2 cycles after the divisor transfer.
// Backpressure: result acks are stalled per transaction to exercise independent output completion.
module tb_divmod;
  localparam int W = 16;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         in1_stb = 1'b0, in2_stb = 1'b0;
  logic         in1_ack, in2_ack;
  logic [W-1:0] out1, out2;
  logic         out1_stb, out2_stb;
  logic         out1_ack = 1'b0, out2_ack = 1'b0;

  int checks = 0;
  int passes = 0;

  divmod #(.bits(W)) dut (
    .clk(clk), .rst(rst),
    .in1(in1), .in1_stb(in1_stb), .in1_ack(in1_ack),
    .in2(in2), .in2_stb(in2_stb), .in2_ack(in2_ack),
    .out1(out1), .out1_stb(out1_stb), .out1_ack(out1_ack),
    .out2(out2), .out2_stb(out2_stb), .out2_ack(out2_ack)
  );

  always #5 clk = ~clk;

  // C-style truncating division, with the divide-by-zero rule layered on top.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = '1;
      r = a;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
    end
  endfunction

  task automatic send_ops(input logic [W-1:0] a, input logic [W-1:0] b, output bit to);
    bit acc;
    int c;
    to = 0;
    in1 = a; in1_stb = 1'b1; c = 0;
    do begin acc = in1_ack; @(posedge clk); #1; c++; end while (!acc && c < 100);
    if (!acc) to = 1;
    in1_stb = 1'b0;
    in2 = b; in2_stb = 1'b1; c = 0;
    do begin acc = in2_ack; @(posedge clk); #1; c++; end while (!acc && c < 100);
    if (!acc) to = 1;
    in2_stb = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit to);
    lat = 0; to = 0;
    while (!(out1_stb || out2_stb) && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!(out1_stb || out2_stb)) to = 1;
  endtask

  task automatic drain(input int s1, input int s2, output bit to, output bit unst);
    logic [W-1:0] q0, r0;
    bit d1, d2, t1, t2;
    int c;
    q0 = out1; r0 = out2; d1 = 0; d2 = 0; to = 0; unst = 0; c = 0;
    while (!(d1 && d2)) begin
      out1_ack = (c >= s1);
      out2_ack = (c >= s2);
      t1 = out1_stb && out1_ack;
      t2 = out2_stb && out2_ack;
      if ((out1_stb && out1 !== q0) || (out2_stb && out2 !== r0)) unst = 1;
      @(posedge clk); #1;
      if (t1) d1 = 1;
      if (t2) d2 = 1;
      c++;
      if (c > 100) begin to = 1; break; end
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int s1, input int s2,
                       output logic [W-1:0] q, output logic [W-1:0] r, output int lat,
                       output bit to, output bit unst, output bit both);
    bit t;
    out1_ack = (s1 == 0);
    out2_ack = (s2 == 0);
    unst = 0;
    send_ops(a, b, to);
    wait_result(lat, t);
    to |= t;
    q = out1; r = out2;
    both = out1_stb && out2_stb;
    if (!t) begin drain(s1, s2, t, unst); to |= t; end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if ({in1_ack, in2_ack, out1_stb, out2_stb} !== 4'b1000) $display("FAIL reset_flags got %b want 1000", {in1_ack, in2_ack, out1_stb, out2_stb}); else passes++;
    checks++; if ({out1, out2} !== 32'h0) $display("FAIL reset_data got %h want 00000000", {out1, out2}); else passes++;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; int lat; bit to, unst, both;
    do_op(16'd100, 16'd7, 0, 0, q, r, lat, to, unst, both);
    checks++; if (to !== 1'b0) $display("FAIL basic_timeout got %b want 0", to); else passes++;
    checks++; if (q !== 16'h000E) $display("FAIL basic_q got %h want 000e", q); else passes++;
    checks++; if (r !== 16'h0002) $display("FAIL basic_r got %h want 0002", r); else passes++;
    checks++; if (lat !== LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT); else passes++;
    checks++; if (both !== 1'b1) $display("FAIL basic_stb_together got %b want 1", both); else passes++;
    checks++; if (in1_ack !== 1'b1) $display("FAIL basic_in1_ack_after got %b want 1", in1_ack); else passes++;
  endtask

  task automatic test_signs();
    logic [W-1:0] ta[3] = '{16'hFF9C, 16'd100, 16'hFF9C};
    logic [W-1:0] tb[3] = '{16'd7, 16'hFFF9, 16'hFFF9};
    logic [W-1:0] eq[3] = '{16'hFFF2, 16'hFFF2, 16'h000E};
    logic [W-1:0] er[3] = '{16'hFFFE, 16'h0002, 16'hFFFE};
    logic [W-1:0] q, r; int lat; bit to, unst, both;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], 0, 0, q, r, lat, to, unst, both);
      checks++; if ({to, q, r} !== {1'b0, eq[i], er[i]}) $display("FAIL signs_%0d got to=%b q=%h r=%h want q=%h r=%h", i, to, q, r, eq[i], er[i]); else passes++;
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta[4] = '{16'd7, 16'h8000, 16'h8000, 16'd5};
    logic [W-1:0] tb[4] = '{16'd0, 16'hFFFF, 16'd1, 16'd9};
    logic [W-1:0] eq[4] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0000};
    logic [W-1:0] er[4] = '{16'h0007, 16'h0000, 16'h0000, 16'h0005};
    logic [W-1:0] q, r; int lat; bit to, unst, both;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 0, 0, q, r, lat, to, unst, both);
      checks++; if ({to, q, r} !== {1'b0, eq[i], er[i]}) $display("FAIL bound_%0d got to=%b q=%h r=%h want q=%h r=%h", i, to, q, r, eq[i], er[i]); else passes++;
      checks++; if (lat !== LAT) $display("FAIL bound_%0d_latency got %0d want %0d", i, lat, LAT); else passes++;
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to, t;
    out1_ack = 1'b1; out2_ack = 1'b0;
    send_ops(16'hFF9C, 16'd7, to);
    wait_result(lat, t);
    checks++; if ({to, t, out1, out2} !== {2'b00, 16'hFFF2, 16'hFFFE}) $display("FAIL bp_result got to=%b%b q=%h r=%h want q=fff2 r=fffe", to, t, out1, out2); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({out1_stb, out2_stb, in1_ack, out2} !== {3'b010, 16'hFFFE}) $display("FAIL bp_hold_%0d got o1stb=%b o2stb=%b in1_ack=%b r=%h want 0 1 0 fffe", i, out1_stb, out2_stb, in1_ack, out2); else passes++;
    end
    out2_ack = 1'b1;
    @(posedge clk); #1;
    checks++; if ({out2_stb, in1_ack} !== 2'b01) $display("FAIL bp_release got o2stb=%b in1_ack=%b want 0 1", out2_stb, in1_ack); else passes++;
    out1_ack = 1'b0; out2_ack = 1'b0;
  endtask

  task automatic test_ordering();
    int lat, c; bit acc, to, unst;
    out1_ack = 1'b1; out2_ack = 1'b1;
    in2 = 16'd7; in2_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (in2_ack !== 1'b0) $display("FAIL order_early_in2_ack_%0d got %b want 0", i, in2_ack); else passes++;
    end
    in1 = 16'd100; in1_stb = 1'b1; c = 0;
    do begin acc = in1_ack; @(posedge clk); #1; c++; end while (!acc && c < 100);
    in1_stb = 1'b0;
    c = 0;
    do begin acc = in2_ack; @(posedge clk); #1; c++; end while (!acc && c < 100);
    in2_stb = 1'b0;
    wait_result(lat, to);
    checks++; if ({to, out1, out2} !== {1'b0, 16'h000E, 16'h0002}) $display("FAIL order_result got to=%b q=%h r=%h want 000e 0002", to, out1, out2); else passes++;
    drain(0, 0, to, unst);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r; int lat; bit to, unst, both, seen;
    send_ops(16'd1000, 16'd3, to);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if ({in1_ack, in2_ack, out1_stb, out2_stb, out1, out2} !== {4'b1000, 32'h0}) $display("FAIL rstmid_outputs got flags=%b q=%h r=%h want 1000 0000 0000", {in1_ack, in2_ack, out1_stb, out2_stb}, out1, out2); else passes++;
    #2 rst = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out1_stb || out2_stb) seen = 1; end
    checks++; if (seen !== 1'b0) $display("FAIL rstmid_no_stb got %b want 0", seen); else passes++;
    do_op(16'd50, 16'd5, 0, 0, q, r, lat, to, unst, both);
    checks++; if ({to, q, r} !== {1'b0, 16'd10, 16'd0}) $display("FAIL rstmid_after got to=%b q=%h r=%h want 000a 0000", to, q, r); else passes++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er; int lat; bit to, unst, both;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      if ($urandom_range(0, 19) == 0) a = 16'h8000;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = '1;
        2: b = W'($urandom_range(0, 30)) - W'(15);
        default: b = W'($urandom);
      endcase
      ref_div(a, b, eq, er);
      do_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3), q, r, lat, to, unst, both);
      checks++;
      if ({to, unst, both, q, r} !== {3'b001, eq, er} || lat != LAT) begin
        bad++;
        $display("FAIL rand_%0d a=%h b=%h got q=%h r=%h lat=%0d to=%b unstable=%b both=%b want q=%h r=%h lat=%0d", i, a, b, q, r, lat, to, unst, both, eq, er, LAT);
        if (to) break;
      end else passes++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_boundaries();
    test_backpressure();
    test_ordering();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
